// File: rtl/sextium_mem_arbiter.sv
// Two-port arbiter in front of a single memory bridge.
// A request is arbitrated in an IDLE cycle, then the winning port owns the
// bridge for the BUSY phase until the bridge acks or the port aborts.
module sextium_mem_arbiter #(
   parameter int unsigned ROUND_ROBIN = 1  // 1: alternate on ties, 0: port 0 always wins
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p0_bus_out,
   input  logic [15:0] p1_bus_out,
   input  logic        p0_read,
   input  logic        p0_write,
   input  logic        p1_read,
   input  logic        p1_write,
   output logic        p0_ack,
   output logic        p1_ack,
   output logic [15:0] p0_bus_in,
   output logic [15:0] p1_bus_in,
   output logic [15:0] addr_bus,
   output logic [15:0] mem_bus_out,
   output logic        mem_read,
   output logic        mem_write,
   input  logic        mem_ack,
   input  logic [15:0] mem_bus_in
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic        gnt_q, gnt_d;    // port that owns the bridge during BUSY
   logic        last_q, last_d;  // port that completed the most recent transfer

   logic        req0, req1;
   logic        sel_read, sel_write, sel_req;
   logic [15:0] sel_addr, sel_wdata;
   logic        busy;

   assign req0 = p0_read | p0_write;
   assign req1 = p1_read | p1_write;

   // Granted port's signals; only meaningful while BUSY.
   assign sel_read  = gnt_q ? p1_read    : p0_read;
   assign sel_write = gnt_q ? p1_write   : p0_write;
   assign sel_addr  = gnt_q ? p1_addr    : p0_addr;
   assign sel_wdata = gnt_q ? p1_bus_out : p0_bus_out;
   assign sel_req   = sel_read | sel_write;

   // Arbitration and transfer-completion decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case below can leave a value unassigned and infer a latch.
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 && req1) begin
               gnt_d   = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
               state_d = ST_BUSY;
            end else if (req0 || req1) begin
               gnt_d   = req1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               last_d  = gnt_q;
               state_d = ST_IDLE;
            end else if (!sel_req) begin
               // Requester withdrew: drop the transfer, fairness history untouched.
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bridge-side strobes and requester acks; forced idle while reset is high.
   always_comb begin
      busy        = (state_q == ST_BUSY) && !reset;
      addr_bus    = busy ? sel_addr  : 16'h0000;
      mem_bus_out = busy ? sel_wdata : 16'h0000;
      mem_write   = busy && sel_write;
      mem_read    = busy && sel_read && !sel_write;  // write wins if both strobes are up
      p0_ack      = busy && !gnt_q && mem_ack;
      p1_ack      = busy &&  gnt_q && mem_ack;
   end

   // Read data is broadcast; each requester qualifies it with its own ack.
   assign p0_bus_in = mem_bus_in;
   assign p1_bus_in = mem_bus_in;

   // State, grant and last-winner registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of its inputs.
      if (reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;  // port 0 takes the first tie
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Self-checking bench: a round-robin instance drives a bridge model with
// programmable wait states; a fixed-priority instance sees the same requests
// through an always-ready bridge. Expected transfers queue up in a scoreboard.
module tb_sextium_mem_arbiter;

   localparam logic [15:0] KEY = 16'hBEFD;  // bridge read data = addr ^ KEY

   typedef struct {
      bit          port;
      logic [15:0] addr;
      bit          wr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] p0_addr = '0, p1_addr = '0, p0_bus_out = '0, p1_bus_out = '0;
   logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;

   // Round-robin instance and its bridge
   logic        p0_ack, p1_ack, mem_read, mem_write, mem_ack;
   logic [15:0] p0_bus_in, p1_bus_in, addr_bus, mem_bus_out, mem_bus_in;
   // Fixed-priority instance and its bridge
   logic        p0_ack_fp, p1_ack_fp, mem_read_fp, mem_write_fp, mem_ack_fp;
   logic [15:0] p0_bus_in_fp, p1_bus_in_fp, addr_bus_fp, mem_bus_out_fp, mem_bus_in_fp;

   bit   hold_wait = 1'b0;
   int   wait_n = 0;
   int   wcnt = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   sextium_mem_arbiter #(.ROUND_ROBIN(1)) dut (
      .clk(clk), .reset(reset),
      .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_bus_out(p0_bus_out), .p1_bus_out(p1_bus_out),
      .p0_read(p0_read), .p0_write(p0_write), .p1_read(p1_read), .p1_write(p1_write),
      .p0_ack(p0_ack), .p1_ack(p1_ack),
      .p0_bus_in(p0_bus_in), .p1_bus_in(p1_bus_in),
      .addr_bus(addr_bus), .mem_bus_out(mem_bus_out),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_ack(mem_ack), .mem_bus_in(mem_bus_in)
   );

   sextium_mem_arbiter #(.ROUND_ROBIN(0)) dut_fp (
      .clk(clk), .reset(reset),
      .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_bus_out(p0_bus_out), .p1_bus_out(p1_bus_out),
      .p0_read(p0_read), .p0_write(p0_write), .p1_read(p1_read), .p1_write(p1_write),
      .p0_ack(p0_ack_fp), .p1_ack(p1_ack_fp),
      .p0_bus_in(p0_bus_in_fp), .p1_bus_in(p1_bus_in_fp),
      .addr_bus(addr_bus_fp), .mem_bus_out(mem_bus_out_fp),
      .mem_read(mem_read_fp), .mem_write(mem_write_fp),
      .mem_ack(mem_ack_fp), .mem_bus_in(mem_bus_in_fp)
   );

   // Bridge model: ack after wait_n stalled cycles unless waitrequest is held.
   assign mem_ack    = (mem_read || mem_write) && !hold_wait && (wcnt >= wait_n);
   assign mem_bus_in = addr_bus ^ KEY;
   always @(posedge clk) begin
      if (mem_ack || !(mem_read || mem_write)) wcnt <= 0;
      else                                     wcnt <= wcnt + 1;
   end

   assign mem_ack_fp    = mem_read_fp || mem_write_fp;
   assign mem_bus_in_fp = addr_bus_fp ^ KEY;

   // Scoreboard monitor: every ack must match the oldest expected transfer.
   always @(negedge clk) begin
      if (!reset && (p0_ack || p1_ack)) begin
         checks++;
         if (p0_ack && p1_ack) begin
            errors++;
            $display("FAIL dual_ack: both acks high at %0t", $time);
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: p0_ack=%0b p1_ack=%0b with empty scoreboard at %0t",
                     p0_ack, p1_ack, $time);
         end else begin
            mon_e = sb_q.pop_front();
            if (p1_ack !== mon_e.port) begin
               errors++;
               $display("FAIL ack_port: got port %0d, expected port %0d", p1_ack, mon_e.port);
            end else if (addr_bus !== mon_e.addr) begin
               errors++;
               $display("FAIL ack_addr: got %h, expected %h", addr_bus, mon_e.addr);
            end else if (mon_e.wr && (mem_write !== 1'b1 || mem_bus_out !== mon_e.wdata)) begin
               errors++;
               $display("FAIL ack_write: mem_write=%0b data=%h, expected 1 data=%h",
                        mem_write, mem_bus_out, mon_e.wdata);
            end else if (!mon_e.wr && (mem_read !== 1'b1 ||
                         (mon_e.port ? p1_bus_in : p0_bus_in) !== mon_e.rdata)) begin
               errors++;
               $display("FAIL ack_read: mem_read=%0b data=%h, expected 1 data=%h", mem_read,
                        (mon_e.port ? p1_bus_in : p0_bus_in), mon_e.rdata);
            end
         end
      end
   end

   task automatic push_exp(input bit port, input logic [15:0] addr, input bit wr,
                           input logic [15:0] wdata);
      exp_t e;
      e.port  = port;
      e.addr  = addr;
      e.wr    = wr;
      e.wdata = wdata;
      e.rdata = addr ^ KEY;
      sb_q.push_back(e);
   endtask

   task automatic drop_all();
      p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1; drop_all(); hold_wait = 0; wait_n = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   // Returns at posedge+1 once the scoreboard is empty, or flags a timeout.
   task automatic wait_drain(input int max_cycles);
      int t = 0;
      while (sb_q.size() != 0 && t < max_cycles) begin
         @(posedge clk);
         t++;
      end
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d transfers outstanding after %0d cycles",
                  sb_q.size(), max_cycles);
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1; p0_read = 1; p0_addr = 16'h00AA; p1_write = 1; p1_addr = 16'h00BB;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, p0_ack, p1_ack} !== 4'b0000 ||
          addr_bus !== 16'h0000 || mem_bus_out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: rd=%0b wr=%0b acks=%0b%0b addr=%h wdata=%h, expected all 0",
                  mem_read, mem_write, p0_ack, p1_ack, addr_bus, mem_bus_out);
      end
      checks++;
      if (p0_bus_in !== KEY || p1_bus_in !== KEY) begin
         errors++;
         $display("FAIL reset_bus_in: p0=%h p1=%h, expected %h", p0_bus_in, p1_bus_in, KEY);
      end
      @(posedge clk); #1;
      reset = 0; drop_all();
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, p0_ack, p1_ack} !== 4'b0000 || addr_bus !== 16'h0000) begin
         errors++;
         $display("FAIL idle_after_reset: rd=%0b wr=%0b acks=%0b%0b addr=%h, expected all 0",
                  mem_read, mem_write, p0_ack, p1_ack, addr_bus);
      end
   endtask

   task automatic test_single_read();
      apply_reset();
      wait_n = 2;
      p0_read = 1; p0_addr = 16'h0012;
      push_exp(1'b0, 16'h0012, 1'b0, 16'h0000);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (mem_read !== (c >= 2 && c <= 4) ||
             ((c >= 2 && c <= 4) && addr_bus !== 16'h0012)) begin
            errors++;
            $display("FAIL single_read_strobe c%0d: mem_read=%0b addr=%h", c, mem_read, addr_bus);
         end
         checks++;
         if (p0_ack !== (c == 4) || p1_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_read_ack c%0d: p0_ack=%0b p1_ack=%0b, expected %0b 0",
                     c, p0_ack, p1_ack, (c == 4));
         end
         if (c == 4) begin
            checks++;
            if (p0_bus_in !== 16'hBEEF) begin
               errors++;
               $display("FAIL single_read_data: got %h, expected BEEF", p0_bus_in);
            end
         end
         @(posedge clk); #1;
         if (c == 4) p0_read = 0;
      end
   endtask

   task automatic test_round_robin();
      int n = 0;
      int prev = -1;
      int cyc = 0;
      apply_reset();
      p0_read = 1; p0_addr = 16'h0100;
      p1_read = 1; p1_addr = 16'h0201;
      for (int i = 0; i < 3; i++) begin
         push_exp(1'b0, 16'h0100, 1'b0, 16'h0000);
         push_exp(1'b1, 16'h0201, 1'b0, 16'h0000);
      end
      while (n < 6 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (p0_ack || p1_ack) begin
            if (prev >= 0) begin
               checks++;
               if (cyc - prev != 2) begin
                  errors++;
                  $display("FAIL rr_spacing: ack gap %0d cycles, expected 2", cyc - prev);
               end
            end
            prev = cyc;
            n++;
         end
         @(posedge clk); #1;
      end
      drop_all();
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL rr_ack_count: %0d acks, expected 6", n);
      end
      wait_drain(4);
   endtask

   task automatic test_fixed_priority();
      int a0 = 0;
      int a1 = 0;
      apply_reset();
      hold_wait = 1;  // keeps the round-robin instance from completing anything
      p0_read = 1; p0_addr = 16'h0010;
      p1_read = 1; p1_addr = 16'h0020;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (p0_ack_fp) a0++;
         if (p1_ack_fp) a1++;
         @(posedge clk); #1;
      end
      checks++;
      if (a0 != 4 || a1 != 0) begin
         errors++;
         $display("FAIL fp_starve: p0 acks %0d p1 acks %0d, expected 4 and 0", a0, a1);
      end
      p0_read = 0;
      @(negedge clk);
      checks++;
      if (p1_ack_fp !== 1'b0 || p0_ack_fp !== 1'b0) begin
         errors++;
         $display("FAIL fp_idle: p0_ack=%0b p1_ack=%0b, expected 0 0", p0_ack_fp, p1_ack_fp);
      end
      @(negedge clk);
      checks++;
      if (p1_ack_fp !== 1'b1 || p1_bus_in_fp !== (16'h0020 ^ KEY)) begin
         errors++;
         $display("FAIL fp_p1_grant: p1_ack=%0b data=%h, expected 1 %h",
                  p1_ack_fp, p1_bus_in_fp, 16'h0020 ^ KEY);
      end
      @(posedge clk); #1;
      drop_all();
      hold_wait = 0;
   endtask

   task automatic test_abort();
      apply_reset();
      p0_read = 1; p0_addr = 16'h0033;  // p0 completes first, so last = 0
      push_exp(1'b0, 16'h0033, 1'b0, 16'h0000);
      wait_drain(10);
      drop_all();
      hold_wait = 1;
      p1_write = 1; p1_addr = 16'h0044; p1_bus_out = 16'h1234;
      repeat (2) begin @(posedge clk); #1; end  // IDLE, BUSY1
      @(negedge clk);                           // BUSY2
      checks++;
      if (mem_write !== 1'b1 || mem_bus_out !== 16'h1234 || p1_ack !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy: wr=%0b data=%h ack=%0b, expected 1 1234 0",
                  mem_write, mem_bus_out, p1_ack);
      end
      @(posedge clk); #1;
      p1_write = 0;
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b0 || p1_ack !== 1'b0 || p0_ack !== 1'b0) begin
         errors++;
         $display("FAIL abort_drop: wr=%0b acks=%0b%0b, expected 0 00", mem_write, p0_ack, p1_ack);
      end
      @(posedge clk); #1;
      hold_wait = 0;
      p0_read = 1;
      p1_write = 1;
      push_exp(1'b1, 16'h0044, 1'b1, 16'h1234);  // last still 0 -> p1 wins the tie
      push_exp(1'b0, 16'h0033, 1'b0, 16'h0000);
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: rd=%0b wr=%0b, expected 0 0", mem_read, mem_write);
      end
      wait_drain(10);
      drop_all();
   endtask

   task automatic test_mid_reset_and_rw();
      apply_reset();
      p0_read = 1; p0_addr = 16'h0011;  // p0 completes first, so last = 0
      push_exp(1'b0, 16'h0011, 1'b0, 16'h0000);
      wait_drain(10);
      drop_all();
      hold_wait = 1;
      p1_write = 1; p1_addr = 16'h0055; p1_bus_out = 16'h7777;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b1 || addr_bus !== 16'h0055) begin
         errors++;
         $display("FAIL midrst_busy: wr=%0b addr=%h, expected 1 0055", mem_write, addr_bus);
      end
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      checks++;
      if (p1_ack !== 1'b0 || p0_ack !== 1'b0) begin
         errors++;
         $display("FAIL midrst_ack: acks=%0b%0b, expected 00", p0_ack, p1_ack);
      end
      @(posedge clk); #1;
      reset = 0; hold_wait = 0;
      p0_read = 1; p0_write = 1; p0_addr = 16'h0066; p0_bus_out = 16'hCAFE;
      push_exp(1'b0, 16'h0066, 1'b1, 16'hCAFE);  // last back to 1 -> p0 wins the tie
      push_exp(1'b1, 16'h0055, 1'b1, 16'h7777);
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after: rd=%0b wr=%0b, expected 0 0", mem_read, mem_write);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || addr_bus !== 16'h0066) begin
         errors++;
         $display("FAIL rw_together: rd=%0b wr=%0b addr=%h, expected 0 1 0066",
                  mem_read, mem_write, addr_bus);
      end
      wait_drain(10);
      drop_all();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_abort();
      test_mid_reset_and_rw();
      repeat (3) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expected transfers never acked", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/sextium_mem_arbiter.md
SEXTIUM_MEM_ARBITER -- requirements
Module: sextium_mem_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1: 1 = alternating priority on contention; 0 = port 0 always wins.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports p0_addr / p1_addr, input, 16: requester word address.
REQ-005 SHALL have ports p0_bus_out / p1_bus_out, input, 16: requester write data.
REQ-006 SHALL have ports p0_read / p1_read and p0_write / p1_write, input, 1 each: requester strobes, held until ack.
REQ-007 SHALL have ports p0_ack / p1_ack, output, 1 each: transfer complete for that requester.
REQ-008 SHALL have ports p0_bus_in / p1_bus_in, output, 16: read data, valid only in the cycle of the matching ack.
REQ-009 SHALL have port addr_bus, output, 16: word address to the memory bridge.
REQ-010 SHALL have port mem_bus_out, output, 16: write data to the memory bridge.
REQ-011 SHALL have ports mem_read / mem_write, output, 1 each: strobes to the memory bridge.
REQ-012 SHALL have port mem_ack, input, 1: bridge completion, meaning (read|write) & ~waitrequest.
REQ-013 SHALL have port mem_bus_in, input, 16: bridge read data.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE and BUSY, plus a 1-bit grant register gnt and a 1-bit last-winner register last.
REQ-015 A port's request SHALL be req_n = pn_read | pn_write.
REQ-016 In IDLE, if exactly one req_n is high, SHALL set gnt = n and go to BUSY next cycle.
REQ-017 In IDLE, with both requests high: if ROUND_ROBIN=1, SHALL grant ~last; if ROUND_ROBIN=0, SHALL grant port 0.
REQ-018 In IDLE, mem_read, mem_write and both acks SHALL be 0; addr_bus and mem_bus_out SHALL be 0.
REQ-019 In BUSY, addr_bus, mem_bus_out, mem_read and mem_write SHALL combinationally follow the granted port's inputs.
REQ-020 If the granted port asserts read and write together, mem_write SHALL follow it and mem_read SHALL be forced to 0.
REQ-021 In BUSY, p<gnt>_ack SHALL equal mem_ack combinationally; the other port's ack SHALL be 0.
REQ-022 Both p0_bus_in and p1_bus_in SHALL be driven by mem_bus_in at all times.
REQ-023 In BUSY, on mem_ack=1: SHALL set last = gnt and return to IDLE next cycle.
REQ-024 Minimum transaction time is 2 cycles: 1 arbitration cycle in IDLE, then at least 1 BUSY cycle; back-to-back requests from one port SHALL therefore have at least one idle cycle between acks.
REQ-025 In BUSY, if the granted port drops both strobes before ack (abort): SHALL return to IDLE next cycle, leave last unchanged, and issue no ack.
REQ-026 A request from the non-granted port during BUSY SHALL be held off (no ack, no bridge strobe) until arbitration in a later IDLE cycle.
REQ-027 Grant SHALL never change while in BUSY.
REQ-028 With ROUND_ROBIN=1, neither port SHALL wait more than one full transaction of the other port.

Reset
REQ-029 On reset=1 at a clock edge: SHALL set state = IDLE, gnt = 0, last = 1 (port 0 wins the first tie).
REQ-030 While reset is high, all outputs SHALL take their IDLE values (REQ-018); the p*_bus_in ports still follow mem_bus_in.
REQ-031 Reset asserted during BUSY SHALL abandon the transfer without ack; mem strobes SHALL be 0 from the following cycle.

Verification
REQ-032 Single read: p0_read=1, p0_addr=0x0012; bridge acks on the 3rd BUSY cycle with mem_bus_in=0xBEEF -> mem_read=1 with addr_bus=0x0012 from cycle 2; p0_ack=1 with p0_bus_in=0xBEEF in exactly one cycle; p1_ack stays 0.
REQ-033 Contention, ROUND_ROBIN=1: both ports request continuously, each bridge access acks in 1 BUSY cycle -> acks alternate p0, p1, p0, p1, one ack every 2 cycles.
REQ-034 Contention, ROUND_ROBIN=0: both ports request continuously -> only p0 is acked; after p0 drops its request, p1 is granted at the next IDLE.
REQ-035 Abort: p1_write=1 with p1_bus_out=0x1234; bridge holds waitrequest; p1 drops the strobe after 2 BUSY cycles -> FSM returns to IDLE; no ack; last unchanged; a following tie goes to the same port as before the abort.
REQ-036 Mid-operation reset and simultaneous strobes: reset during BUSY -> no ack, mem_write=0 the next cycle, first tie after reset goes to p0; p0_read=p0_write=1 -> mem_write=1, mem_read=0.
